sequencer2: RTL and testbench

Parametrised successor to the single-channel program sequencer. Steps through a constant program held in a parameter and drives a data word per instruction. Supports timed output, jumps, subroutine calls and counted loops, plus an external-trigger wait, a run enable, stack-error reporting and asynchronous reset. Sits between control logic, which selects entry points via `addr`/`jump`, and whatever consumes `data_o`.

---
 rtl/sequencer2.sv | 218 +++++++++++++++++++++
 tb/tb_sequencer2.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sequencer2.sv
// sequencer2: parametrised program sequencer with timed output, jumps, calls, counted loops and stack-error flag.
// Optional WAIT-on-trigger opcode is built when SEQUENCER2_WAIT_EN is defined; otherwise op 7 acts as STOP.
`timescale 1ns/1ps
module sequencer2 #(
    parameter int DW   = 4,
    parameter int AW   = 5,
    parameter int PLEN = 31,
    parameter int SD   = 8,
    parameter logic [PLEN*(3+AW+DW)-1:0] PROGRAM = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [AW-1:0] addr,
    input  logic          jump,
    input  logic          trig,
    output logic [DW-1:0] data_o,
    output logic [AW-1:0] pc,
    output logic          stop,
    output logic          err
);

    localparam int WW  = 3 + AW + DW;
    localparam int SPW = $clog2(SD + 1);
    localparam int IW  = (SD > 1) ? $clog2(SD) : 1;
    localparam logic [SPW-1:0] SP_FULL = SPW'(SD);

    typedef enum logic [2:0] {
        OP_STOP   = 3'd0,
        OP_OUT    = 3'd1,
        OP_JMP    = 3'd2,
        OP_CALL   = 3'd3,
        OP_RET    = 3'd4,
        OP_PUSHI  = 3'd5,
        OP_DECJNZ = 3'd6,
        OP_WAIT   = 3'd7
    } op_e;

    // Word 0 sits in the most significant slot; addresses past the program read as STOP, d=0.
    function automatic logic [WW-1:0] fetch(input logic [AW-1:0] a);
        logic [WW-1:0] w;
        if (int'(a) < PLEN) begin
            w = PROGRAM[(PLEN - 1 - int'(a)) * WW +: WW];
        end else begin
            w = {WW{1'b0}};
        end
        return w;
    endfunction

    logic [AW-1:0]  pc_r, cnt_r;
    logic [SPW-1:0] sp_r;
    logic           err_r;
    logic [AW-1:0]  stack_r [SD];

    logic [WW-1:0]  word_s;
    op_e            op_s;
    logic [AW-1:0]  n_s, n_eff_s, pc_inc_s, top_s;
    logic [AW:0]    cnt_plus_s;
    logic [SPW-1:0] sp_m1_s;
    logic [IW-1:0]  top_idx_s;
    logic           sp_empty_s;

    logic [AW-1:0]  pc_nxt_s, cnt_nxt_s, push_val_s, stk_wd_s;
    logic [SPW-1:0] sp_nxt_s;
    logic           err_nxt_s, push_s, dwell_s, stk_we_s;
    logic [IW-1:0]  stk_wa_s;

    assign word_s     = fetch(pc_r);
    assign op_s       = op_e'(word_s[WW-1 -: 3]);
    assign n_s        = word_s[DW +: AW];
    assign n_eff_s    = (n_s == {AW{1'b0}}) ? AW'(1) : n_s;
    assign pc_inc_s   = pc_r + AW'(1);
    assign cnt_plus_s = {1'b0, cnt_r} + (AW+1)'(1);
    assign sp_m1_s    = sp_r - SPW'(1);
    assign top_idx_s  = sp_m1_s[IW-1:0];
    assign top_s      = stack_r[top_idx_s];
    assign sp_empty_s = (sp_r == {SPW{1'b0}});

    assign data_o = word_s[DW-1:0];
    assign pc     = pc_r;
    assign err    = err_r;

`ifdef SEQUENCER2_WAIT_EN
    assign stop = (op_s == OP_STOP);
`else
    logic unused_trig_s;
    assign unused_trig_s = trig;
    assign stop = (op_s == OP_STOP) || (op_s == OP_WAIT);
`endif

    // Next-state decode: instruction execution, dwell counting and stack bookkeeping.
    always_comb begin
        pc_nxt_s   = pc_r;
        cnt_nxt_s  = cnt_r;
        sp_nxt_s   = sp_r;
        err_nxt_s  = err_r;
        push_s     = 1'b0;
        push_val_s = {AW{1'b0}};
        dwell_s    = 1'b0;
        stk_we_s   = 1'b0;
        stk_wa_s   = {IW{1'b0}};
        stk_wd_s   = {AW{1'b0}};
        if (jump) begin
            pc_nxt_s  = addr;
            cnt_nxt_s = {AW{1'b0}};
            sp_nxt_s  = {SPW{1'b0}};
            err_nxt_s = 1'b0;
        end else if (en) begin
            case (op_s)
                OP_STOP:  pc_nxt_s = pc_r;
                OP_OUT:   dwell_s  = 1'b1;
                OP_JMP:   pc_nxt_s = n_s;
                OP_CALL: begin
                    push_s     = 1'b1;
                    push_val_s = pc_inc_s;
                    pc_nxt_s   = n_s;
                end
                OP_RET: begin
                    if (!sp_empty_s) begin
                        pc_nxt_s = top_s;
                        sp_nxt_s = sp_m1_s;
                    end else begin
                        dwell_s = 1'b1;
                    end
                end
                OP_PUSHI: begin
                    push_s     = 1'b1;
                    push_val_s = n_s;
                    pc_nxt_s   = pc_inc_s;
                end
                OP_DECJNZ: begin
                    if (sp_empty_s) begin
                        err_nxt_s = 1'b1;
                        pc_nxt_s  = pc_inc_s;
                    end else if (top_s > AW'(1)) begin
                        stk_we_s = 1'b1;
                        stk_wa_s = top_idx_s;
                        stk_wd_s = top_s - AW'(1);
                        pc_nxt_s = n_s;
                    end else begin
                        sp_nxt_s = sp_m1_s;
                        pc_nxt_s = pc_inc_s;
                    end
                end
`ifdef SEQUENCER2_WAIT_EN
                OP_WAIT: begin
                    if (trig) begin
                        pc_nxt_s = pc_inc_s;
                    end else begin
                        pc_nxt_s = pc_r;
                    end
                end
`else
                OP_WAIT:  pc_nxt_s = pc_r;
`endif
                default:  pc_nxt_s = pc_r;
            endcase

            if (dwell_s) begin
                if (cnt_plus_s >= {1'b0, n_eff_s}) begin
                    pc_nxt_s  = pc_inc_s;
                    cnt_nxt_s = {AW{1'b0}};
                end else begin
                    cnt_nxt_s = cnt_plus_s[AW-1:0];
                end
            end else if (pc_nxt_s != pc_r) begin
                cnt_nxt_s = {AW{1'b0}};
            end else begin
                cnt_nxt_s = cnt_r;
            end

            // A push into a full stack is dropped but the instruction still completes.
            if (push_s) begin
                if (sp_r == SP_FULL) begin
                    err_nxt_s = 1'b1;
                end else begin
                    stk_we_s = 1'b1;
                    stk_wa_s = sp_r[IW-1:0];
                    stk_wd_s = push_val_s;
                    sp_nxt_s = sp_r + SPW'(1);
                end
            end else begin
                sp_nxt_s = sp_nxt_s;
            end
        end else begin
            pc_nxt_s = pc_r;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r  <= {AW{1'b0}};
            cnt_r <= {AW{1'b0}};
            sp_r  <= {SPW{1'b0}};
            err_r <= 1'b0;
        end else begin
            pc_r  <= pc_nxt_s;
            cnt_r <= cnt_nxt_s;
            sp_r  <= sp_nxt_s;
            err_r <= err_nxt_s;
        end
    end

    // Return/loop-count stack storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SD; i++) begin
                stack_r[i] <= {AW{1'b0}};
            end
        end else if (stk_we_s) begin
            stack_r[stk_wa_s] <= stk_wd_s;
        end else begin
            stack_r <= stack_r;
        end
    end

endmodule

// File: tb/tb_sequencer2.sv
// Bench for sequencer2: directed vector table, hand-written multi-cycle sequences and a randomized run
// checked against a queue-based reference model of the instruction rules.
`timescale 1ns/1ps
module tb_sequencer2;

    localparam int DW = 4, AW = 5, PLEN = 31, SD = 8, WW = 12;
`ifdef SEQUENCER2_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    localparam logic [PLEN*WW-1:0] PROG = {
        {3'd0, 5'd0,  4'hA},  // 0  STOP
        {3'd7, 5'd0,  4'h1},  // 1  WAIT
        {3'd1, 5'd3,  4'h2},  // 2  OUT 3
        {3'd1, 5'd0,  4'h3},  // 3  OUT 0
        {3'd0, 5'd0,  4'h4},  // 4  STOP
        {3'd5, 5'd5,  4'h5},  // 5  PUSHI 5
        {3'd3, 5'd9,  4'h6},  // 6  CALL 9
        {3'd6, 5'd6,  4'h7},  // 7  DECJNZ 6
        {3'd6, 5'd0,  4'h8},  // 8  DECJNZ (empty-stack probe)
        {3'd4, 5'd0,  4'h9},  // 9  RET
        {3'd5, 5'd1,  4'hB}, {3'd5, 5'd1, 4'hB}, {3'd5, 5'd1, 4'hB},
        {3'd5, 5'd1,  4'hB}, {3'd5, 5'd1, 4'hB}, {3'd5, 5'd1, 4'hB},
        {3'd5, 5'd1,  4'hB}, {3'd5, 5'd1, 4'hB}, {3'd5, 5'd1, 4'hB},  // 10..18 PUSHI
        {3'd0, 5'd0,  4'hF},  // 19 STOP
        {3'd1, 5'd4,  4'hC},  // 20 OUT 4
        {3'd0, 5'd0,  4'hD},  // 21 STOP
        {3'd6, 5'd0,  4'h6},  // 22 DECJNZ
        {3'd4, 5'd2,  4'h7},  // 23 RET (n=2)
        {3'd1, 5'd1,  4'h8},  // 24 OUT 1
        {3'd2, 5'd30, 4'h9},  // 25 JMP 30
        12'h000, 12'h000, 12'h000, 12'h000,
        {3'd1, 5'd0,  4'hE}   // 30 OUT 0
    };

    logic          clk = 1'b0;
    logic          rst_n, en, jump, trig;
    logic [AW-1:0] addr;
    logic [DW-1:0] data_o;
    logic [AW-1:0] pc;
    logic          stop, err;

    sequencer2 #(.DW(DW), .AW(AW), .PLEN(PLEN), .SD(SD), .PROGRAM(PROG)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .addr(addr), .jump(jump), .trig(trig),
        .data_o(data_o), .pc(pc), .stop(stop), .err(err)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    task automatic check(input string name, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: program counter, dwell count, error flag and a queue as the stack.
    logic [PLEN*WW-1:0] prog_v = PROG;
    int  m_pc, m_cnt;
    bit  m_err;
    int  stk[$];

    function automatic logic [WW-1:0] m_word(input int p);
        if (p >= PLEN) return '0;
        return prog_v[(PLEN - 1 - p) * WW +: WW];
    endfunction

    function automatic int m_data();
        logic [WW-1:0] w;
        w = m_word(m_pc);
        return int'(w[3:0]);
    endfunction

    function automatic int m_stop();
        logic [WW-1:0] w;
        w = m_word(m_pc);
        return (w[11:9] == 3'd0 || (w[11:9] == 3'd7 && !WAIT_EN)) ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_pc = 0; m_cnt = 0; m_err = 0; stk.delete();
    endtask

    task automatic model_push(input int v);
        if (stk.size() >= SD) m_err = 1;
        else stk.push_back(v);
    endtask

    task automatic model_step(input logic j, input logic [4:0] a, input logic e, input logic t);
        logic [WW-1:0] w;
        int op, n, ne, old_pc, top;
        if (j) begin
            m_pc = a; m_cnt = 0; m_err = 0; stk.delete();
            return;
        end
        if (!e) return;
        old_pc = m_pc;
        w  = m_word(m_pc);
        op = w[11:9];
        n  = w[8:4];
        ne = (n == 0) ? 1 : n;
        case (op)
            1: if (m_cnt + 1 >= ne) m_pc = m_pc + 1; else m_cnt++;
            2: m_pc = n;
            3: begin model_push((m_pc + 1) % 32); m_pc = n; end
            4: begin
                if (stk.size() > 0) m_pc = stk.pop_back();
                else if (m_cnt + 1 >= ne) m_pc = m_pc + 1;
                else m_cnt++;
            end
            5: begin model_push(n); m_pc = m_pc + 1; end
            6: begin
                if (stk.size() == 0) begin m_err = 1; m_pc = m_pc + 1; end
                else begin
                    top = stk[$];
                    if (top > 1) begin stk[stk.size()-1] = top - 1; m_pc = n; end
                    else begin void'(stk.pop_back()); m_pc = m_pc + 1; end
                end
            end
            7: if (WAIT_EN && t) m_pc = m_pc + 1;
            default: ;
        endcase
        m_pc = m_pc % 32;
        if (m_pc != old_pc) m_cnt = 0;
    endtask

    // One clock: inputs driven after the falling edge, outputs observed at the next falling edge.
    task automatic cycle(input logic j, input logic [4:0] a, input logic e, input logic t);
        jump = j; addr = a; en = e; trig = t;
        @(posedge clk);
        model_step(j, a, e, t);
        @(negedge clk);
    endtask

    typedef struct {
        logic       j;
        logic [4:0] a;
        logic       e;
        logic       t;
        int         pc;
        int         d;
        int         stp;
        int         er;
    } vec_t;

    vec_t vecs[26];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int entries, steps;
        logic j, e, t;
        logic [4:0] a;

        vecs[0]  = '{1'b1, 5'd2,  1'b1, 1'b0,  2,  2, 0, 0};
        vecs[1]  = '{1'b0, 5'd0,  1'b1, 1'b0,  2,  2, 0, 0};
        vecs[2]  = '{1'b0, 5'd0,  1'b1, 1'b0,  2,  2, 0, 0};
        vecs[3]  = '{1'b0, 5'd0,  1'b1, 1'b0,  3,  3, 0, 0};
        vecs[4]  = '{1'b0, 5'd0,  1'b1, 1'b0,  4,  4, 1, 0};
        vecs[5]  = '{1'b0, 5'd0,  1'b1, 1'b0,  4,  4, 1, 0};
        vecs[6]  = '{1'b1, 5'd20, 1'b1, 1'b0, 20, 12, 0, 0};
        vecs[7]  = '{1'b0, 5'd0,  1'b1, 1'b0, 20, 12, 0, 0};
        for (int i = 8; i <= 12; i++) vecs[i] = '{1'b0, 5'd0, 1'b0, 1'b1, 20, 12, 0, 0};
        vecs[13] = '{1'b0, 5'd0,  1'b1, 1'b0, 20, 12, 0, 0};
        vecs[14] = '{1'b0, 5'd0,  1'b1, 1'b0, 20, 12, 0, 0};
        vecs[15] = '{1'b0, 5'd0,  1'b1, 1'b0, 21, 13, 1, 0};
        vecs[16] = '{1'b1, 5'd5,  1'b0, 1'b0,  5,  5, 0, 0};
        vecs[17] = '{1'b1, 5'd22, 1'b1, 1'b0, 22,  6, 0, 0};
        vecs[18] = '{1'b0, 5'd0,  1'b1, 1'b0, 23,  7, 0, 1};
        vecs[19] = '{1'b0, 5'd0,  1'b1, 1'b0, 23,  7, 0, 1};
        vecs[20] = '{1'b0, 5'd0,  1'b1, 1'b0, 24,  8, 0, 1};
        vecs[21] = '{1'b0, 5'd0,  1'b1, 1'b0, 25,  9, 0, 1};
        vecs[22] = '{1'b0, 5'd0,  1'b1, 1'b0, 30, 14, 0, 1};
        vecs[23] = '{1'b0, 5'd0,  1'b1, 1'b0, 31,  0, 1, 1};
        vecs[24] = '{1'b0, 5'd0,  1'b1, 1'b0, 31,  0, 1, 1};
        vecs[25] = '{1'b1, 5'd0,  1'b1, 1'b0,  0, 10, 1, 0};

        rst_n = 1'b0; en = 1'b0; jump = 1'b0; trig = 1'b0; addr = 5'd0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_pc", pc, 0);
            check("reset_err", err, 0);
            check("reset_data", data_o, 10);
            check("reset_stop", stop, 1);
        end
        rst_n = 1'b1;
        cycle(1'b0, 5'd0, 1'b1, 1'b0);
        check("post_reset_pc", pc, 0);
        check("post_reset_data", data_o, 10);

        for (int i = 0; i < 26; i++) begin
            cycle(vecs[i].j, vecs[i].a, vecs[i].e, vecs[i].t);
            check($sformatf("vec%0d_pc", i), pc, vecs[i].pc);
            check($sformatf("vec%0d_data", i), data_o, vecs[i].d);
            check($sformatf("vec%0d_stop", i), stop, vecs[i].stp);
            check($sformatf("vec%0d_err", i), err, vecs[i].er);
        end

        // Counted loop around a subroutine call.
        cycle(1'b1, 5'd5, 1'b1, 1'b0);
        entries = 0;
        steps = 0;
        while (pc != 5'd8 && steps < 80) begin
            cycle(1'b0, 5'd0, 1'b1, 1'b0);
            steps++;
            if (pc == 5'd9) entries++;
        end
        check("loop_reached_exit", pc, 8);
        check("loop_entries", entries, 5);
        check("loop_err", err, 0);
        cycle(1'b0, 5'd0, 1'b1, 1'b0);
        check("loop_stack_empty_pc", pc, 9);
        check("loop_stack_empty_err", err, 1);

        // Stack overflow with nine pushes into an eight-deep stack.
        cycle(1'b1, 5'd10, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) begin
            cycle(1'b0, 5'd0, 1'b1, 1'b0);
            check($sformatf("ovf%0d_pc", i), pc, 11 + i);
            check($sformatf("ovf%0d_err", i), err, (i == 8) ? 1 : 0);
        end
        cycle(1'b1, 5'd0, 1'b0, 1'b0);
        check("ovf_clear_err", err, 0);

        // WAIT opcode.
        cycle(1'b1, 5'd1, 1'b1, 1'b0);
        check("wait_stop", stop, WAIT_EN ? 0 : 1);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 5'd0, 1'b1, 1'b0);
            check($sformatf("wait_hold%0d", i), pc, 1);
        end
        cycle(1'b0, 5'd0, 1'b1, 1'b1);
        check("wait_release_pc", pc, WAIT_EN ? 2 : 1);
        cycle(1'b0, 5'd0, 1'b1, 1'b1);
        check("wait_after_pc", pc, WAIT_EN ? 2 : 1);

        // Randomized run against the reference model, with one asynchronous reset mid-way.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                #2 rst_n = 1'b0;
                #1;
                check("async_reset_pc", pc, 0);
                check("async_reset_err", err, 0);
                check("async_reset_data", data_o, 10);
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
            end
            j = ($urandom_range(0, 99) < 4);
            a = 5'($urandom_range(0, 31));
            e = ($urandom_range(0, 99) < 85);
            t = ($urandom_range(0, 99) < 30);
            cycle(j, a, e, t);
            check("rand_pc", pc, m_pc);
            check("rand_data", data_o, m_data());
            check("rand_stop", stop, m_stop());
            check("rand_err", err, m_err);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
